// File: rtl/sattn_rocc_cmd_bridge_pkg.sv
// sattn_rocc_cmd_bridge_pkg: register map, RoCC funct7 codes, bridge FSM encoding and command descriptor
package sattn_rocc_cmd_bridge_pkg;
  localparam int DATA_W = 64;
  localparam logic [15:0] REG_CMD       = 16'h0060;
  localparam logic [15:0] REG_IDX_WADDR = 16'h0070;
  localparam logic [15:0] REG_IDX_WDATA = 16'h0078;
  typedef enum logic [6:0] {
    F_CFG_WR = 7'h00,
    F_CFG_RD = 7'h01,
    F_LAUNCH = 7'h02,
    F_IDX_LD = 7'h03,
    F_STATUS = 7'h04
  } funct7_e;
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WR        = 4'd1;
  localparam logic [3:0] S_RD        = 4'd2;
  localparam logic [3:0] S_IDX_A     = 4'd3;
  localparam logic [3:0] S_IDX_D     = 4'd4;
  localparam logic [3:0] S_GAP       = 4'd5;
  localparam logic [3:0] S_LAUNCH_WR = 4'd6;
  localparam logic [3:0] S_WAIT_DONE = 4'd7;
  localparam logic [3:0] S_SETTLE    = 4'd8;
  localparam logic [3:0] S_RES_RD    = 4'd9;
  localparam logic [3:0] S_RESP      = 4'd10;
  typedef struct packed {
    logic [15:0]       rs1;
    logic [DATA_W-1:0] rs2;
    logic [4:0]        rd;
    logic              xd;
  } desc_t;
endpackage

// File: rtl/sattn_rocc_cmd_bridge.sv
// sattn_rocc_cmd_bridge: turns RoCC commands into MMIO register sequences and returns RoCC responses
module sattn_rocc_cmd_bridge
  import sattn_rocc_cmd_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [6:0]            cmd_funct7,
  input  logic [DATA_WIDTH-1:0] cmd_rs1,
  input  logic [DATA_WIDTH-1:0] cmd_rs2,
  input  logic [4:0]            cmd_rd,
  input  logic                  cmd_xd,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [4:0]            resp_rd,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  mmio_wen,
  output logic                  mmio_ren,
  output logic [ADDR_WIDTH-1:0] mmio_addr,
  output logic [DATA_WIDTH-1:0] mmio_wdata,
  input  logic [DATA_WIDTH-1:0] mmio_rdata,
  input  logic                  acc_done,
  output logic                  bridge_busy,
  output logic                  err_sticky
);
  logic [3:0]            state_q, state_d;
  desc_t                 desc_q, desc_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [31:0]           cnt_q, cnt_d, tev_q, tev_d;
  logic                  err_q, err_d;
  logic [3:0]            fin_cmd, fin_desc;
  logic                  unused_rs1_hi;
  assign unused_rs1_hi = ^cmd_rs1[DATA_WIDTH-1:16];
  assign fin_cmd  = cmd_xd ? S_RESP : S_IDLE;
  assign fin_desc = desc_q.xd ? S_RESP : S_IDLE;
  // Next-state, descriptor capture, result latching and error/timeout bookkeeping
  always_comb begin
    state_d = state_q;
    desc_d  = desc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    tev_d   = tev_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        desc_d = '{rs1: cmd_rs1[15:0], rs2: DATA_W'(cmd_rs2), rd: cmd_rd, xd: cmd_xd};
        res_d  = '0;
        case (cmd_funct7)
          F_CFG_WR: state_d = S_WR;
          F_CFG_RD: state_d = S_RD;
          F_LAUNCH: state_d = S_LAUNCH_WR;
          F_IDX_LD: state_d = S_IDX_A;
          F_STATUS: begin
            res_d   = DATA_WIDTH'({err_q, 31'b0, tev_q});
            err_d   = 1'b0;
            state_d = fin_cmd;
          end
          default: begin
            res_d   = '1;
            err_d   = 1'b1;
            state_d = fin_cmd;
          end
        endcase
      end
      S_WR:    state_d = fin_desc;
      S_RD: begin
        res_d   = mmio_rdata;
        state_d = fin_desc;
      end
      S_IDX_A: state_d = S_IDX_D;
      S_IDX_D: state_d = S_GAP;
      S_GAP:   state_d = fin_desc;
      S_LAUNCH_WR: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + 32'd1;
        if (acc_done) state_d = S_SETTLE;
        else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          tev_d   = tev_q + 32'(tev_q != '1);
          res_d   = '1;
          state_d = fin_desc;
        end
      end
      S_SETTLE: state_d = S_RES_RD;
      S_RES_RD: begin
        res_d   = mmio_rdata;
        state_d = fin_desc;
      end
      S_RESP:  state_d = resp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  // State and bookkeeping registers; reset aborts any command in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      desc_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      tev_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      tev_q   <= tev_d;
      err_q   <= err_d;
    end
  end
  assign cmd_ready   = state_q == S_IDLE;
  assign bridge_busy = !cmd_ready;
  assign err_sticky  = err_q;
  assign resp_valid  = state_q == S_RESP;
  assign resp_rd     = resp_valid ? desc_q.rd : '0;
  assign resp_data   = resp_valid ? res_q : '0;
  assign mmio_wen    = state_q == S_WR || state_q == S_IDX_A || state_q == S_IDX_D || state_q == S_LAUNCH_WR;
  assign mmio_ren    = state_q == S_RD || state_q == S_RES_RD;
  // MMIO address/data per access state; bus is driven to zero when no access is active
  always_comb begin
    mmio_addr  = '0;
    mmio_wdata = '0;
    case (state_q)
      S_WR: begin
        mmio_addr  = ADDR_WIDTH'(desc_q.rs1);
        mmio_wdata = DATA_WIDTH'(desc_q.rs2);
      end
      S_RD:     mmio_addr = ADDR_WIDTH'(desc_q.rs1);
      S_LAUNCH_WR: begin
        mmio_addr  = ADDR_WIDTH'(REG_CMD);
        mmio_wdata = DATA_WIDTH'(desc_q.rs1[7:0]);
      end
      S_IDX_A: begin
        mmio_addr  = ADDR_WIDTH'(REG_IDX_WADDR);
        mmio_wdata = DATA_WIDTH'(desc_q.rs1);
      end
      S_IDX_D: begin
        mmio_addr  = ADDR_WIDTH'(REG_IDX_WDATA);
        mmio_wdata = DATA_WIDTH'(desc_q.rs2[15:0]);
      end
      S_RES_RD: mmio_addr = ADDR_WIDTH'(desc_q.rs2[15:0]);
      default: ;
    endcase
  end
endmodule

// File: tb/tb_sattn_rocc_cmd_bridge.sv
// tb_sattn_rocc_cmd_bridge: directed and random RoCC commands checked against a transaction-level model
module tb_sattn_rocc_cmd_bridge;
  localparam int TO = 16;
  logic        clk = 1'b0;
  logic        rstn, cmd_valid, cmd_ready, cmd_xd, resp_valid, resp_ready;
  logic [6:0]  cmd_funct7;
  logic [63:0] cmd_rs1, cmd_rs2, resp_data, mmio_wdata, mmio_rdata;
  logic [4:0]  cmd_rd, resp_rd;
  logic        mmio_wen, mmio_ren, acc_done, bridge_busy, err_sticky;
  logic [15:0] mmio_addr;
  logic [47:0] rd_salt;
  int          checks = 0, errors = 0;
  logic        m_err;
  logic [31:0] m_tev;
  typedef struct {int c; logic w; logic [15:0] a; logic [63:0] d;} op_t;
  op_t exq[$];

  always #5 clk = ~clk;
  assign mmio_rdata = {rd_salt, mmio_addr};

  sattn_rocc_cmd_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct7(cmd_funct7),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_xd(cmd_xd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd), .resp_data(resp_data),
    .mmio_wen(mmio_wen), .mmio_ren(mmio_ren), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_rdata(mmio_rdata), .acc_done(acc_done), .bridge_busy(bridge_busy), .err_sticky(err_sticky)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, bridge_busy, 0);
    chk({tag, "_resp"}, {resp_valid, resp_rd, resp_data}, 0);
    chk({tag, "_strobes"}, {mmio_wen, mmio_ren}, 0);
    chk({tag, "_bus"}, {mmio_addr, mmio_wdata}, 0);
    chk({tag, "_err"}, err_sticky, 0);
  endtask

  // One RoCC command: model computes expected MMIO trace, response and latency from the rules
  task automatic do_cmd(input logic [6:0] f, input logic [63:0] rs1, input logic [63:0] rs2,
                        input logic [4:0] rd, input logic xd, input int done_at, input int stall,
                        input int rst_at);
    int lat, c;
    logic [63:0] er, held;
    logic seen;
    op_t o;
    exq.delete();
    rd_salt = 48'({$urandom(), $urandom()});
    er = '0;
    lat = 1;
    case (f)
      7'h00: begin exq.push_back('{c: 1, w: 1'b1, a: rs1[15:0], d: rs2}); lat = 2; end
      7'h01: begin exq.push_back('{c: 1, w: 1'b0, a: rs1[15:0], d: 64'd0}); lat = 2; er = {rd_salt, rs1[15:0]}; end
      7'h02: begin
        exq.push_back('{c: 1, w: 1'b1, a: 16'h0060, d: {56'd0, rs1[7:0]}});
        if (done_at >= 2 && done_at < 2 + TO) begin
          exq.push_back('{c: done_at + 2, w: 1'b0, a: rs2[15:0], d: 64'd0});
          lat = done_at + 3;
          er = {rd_salt, rs2[15:0]};
        end else begin
          lat = 2 + TO;
          er = '1;
          m_err = 1'b1;
          if (m_tev != '1) m_tev++;
        end
      end
      7'h03: begin
        exq.push_back('{c: 1, w: 1'b1, a: 16'h0070, d: {48'd0, rs1[15:0]}});
        exq.push_back('{c: 2, w: 1'b1, a: 16'h0078, d: {48'd0, rs2[15:0]}});
        lat = 4;
      end
      7'h04: begin er = {m_err, 31'd0, m_tev}; m_err = 1'b0; end
      default: begin er = '1; m_err = 1'b1; end
    endcase
    @(negedge clk);
    chk("cmd_ready_before", cmd_ready, 1);
    cmd_funct7 = f; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_xd = xd;
    cmd_valid = 1'b1;
    resp_ready = (stall == 0);
    seen = 1'b0;
    held = '0;
    for (c = 1; c < 300; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      acc_done = 1'b0;
      if (c == rst_at) begin
        rstn = 1'b0;
        #1;
        m_err = 1'b0;
        m_tev = '0;
        chk_idle("mid_reset");
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("post_reset_no_resp", {resp_valid, bridge_busy, mmio_wen, mmio_ren}, 0);
        end
        resp_ready = 1'b1;
        return;
      end
      chk("wen_ren_excl", mmio_wen & mmio_ren, 0);
      if (!mmio_wen && !mmio_ren) chk("idle_bus_zero", {mmio_addr, mmio_wdata}, 0);
      if (mmio_wen || mmio_ren) begin
        if (exq.size() == 0) chk("unexpected_op_cycle", c, 0);
        else begin
          o = exq.pop_front();
          chk("op_cycle", c, o.c);
          chk("op_kind_wen", mmio_wen, o.w);
          chk("op_addr", mmio_addr, o.a);
          if (o.w) chk("op_wdata", mmio_wdata, o.d);
        end
      end
      if (!xd) chk("no_resp_xd0", resp_valid, 0);
      if (resp_valid && seen) chk("resp_stable", {resp_rd, resp_data} == {rd, held}, 1);
      if (resp_valid && !seen) begin
        seen = 1'b1;
        held = resp_data;
        chk("resp_latency", c, lat);
        chk("resp_data", resp_data, er);
        chk("resp_rd", resp_rd, rd);
      end
      if (seen && c == lat + stall) resp_ready = 1'b1;
      if (cmd_ready) begin
        chk("end_cycle", c, xd ? lat + stall + 1 : lat);
        break;
      end
      if (c == done_at) acc_done = 1'b1;
    end
    acc_done = 1'b0;
    resp_ready = 1'b1;
    if (c >= 300) chk("cycle_budget_expired", 1, 0);
    if (xd) chk("resp_seen", seen, 1);
    chk("ops_left", exq.size(), 0);
    chk("err_sticky", err_sticky, m_err);
  endtask

  initial begin
    logic [6:0] f;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_funct7 = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
    cmd_xd = 1'b0; resp_ready = 1'b1; acc_done = 1'b0; rd_salt = '0;
    m_err = 1'b0; m_tev = '0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk_idle("after_reset");
    do_cmd(7'h00, 64'h30, 64'h7, 5'd3, 1'b1, 0, 0, 0);
    do_cmd(7'h01, 64'h30, 64'h0, 5'd4, 1'b1, 0, 0, 0);
    do_cmd(7'h03, 64'h5, 64'h1234, 5'd5, 1'b1, 0, 0, 0);
    do_cmd(7'h02, 64'h14, 64'h68, 5'd6, 1'b1, 12, 0, 0);
    do_cmd(7'h02, 64'h14, 64'h68, 5'd7, 1'b1, 2, 0, 0);
    do_cmd(7'h02, 64'h14, 64'h68, 5'd8, 1'b1, 2 + TO - 1, 0, 0);
    do_cmd(7'h02, 64'h14, 64'h68, 5'd9, 1'b1, 0, 0, 0);
    do_cmd(7'h02, 64'h15, 64'h68, 5'd10, 1'b1, 1, 0, 0);
    do_cmd(7'h04, 64'h0, 64'h0, 5'd11, 1'b1, 0, 0, 0);
    do_cmd(7'h04, 64'h0, 64'h0, 5'd12, 1'b1, 0, 0, 0);
    do_cmd(7'h55, 64'h1, 64'h2, 5'd13, 1'b1, 0, 0, 0);
    do_cmd(7'h7f, 64'h1, 64'h2, 5'd14, 1'b0, 0, 0, 0);
    do_cmd(7'h00, 64'hffff_0040, 64'hdead_beef_0bad_f00d, 5'd15, 1'b0, 0, 0, 0);
    do_cmd(7'h01, 64'h44, 64'h0, 5'd16, 1'b1, 0, 10, 0);
    @(negedge clk);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    chk("stray_done_idle", {cmd_ready, bridge_busy, mmio_wen, mmio_ren}, 4'b1000);
    do_cmd(7'h02, 64'h14, 64'h68, 5'd17, 1'b1, 0, 0, 8);
    do_cmd(7'h04, 64'h0, 64'h0, 5'd18, 1'b1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      f = 7'($urandom_range(0, 5));
      if (f == 7'd5) f = 7'($urandom_range(5, 127));
      do_cmd(f, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 5'($urandom()),
             1'($urandom_range(0, 3) != 0), $urandom_range(0, 20), $urandom_range(0, 3), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
